// File: rtl/spi_slave_regfile_if.sv
// spi_slave_regfile_if: SPI pins plus register-image/status outputs of the SPI register file
interface spi_slave_regfile_if #(parameter int N_REGS = 16);
  logic                  SCLK;
  logic                  SDI;
  logic                  SEN;
  logic                  SDO;
  logic [8*N_REGS-1:0]   REGS;
  logic                  WR_STROBE;
  logic [6:0]            WR_ADDR;
  logic                  FRAME_ERROR;
  logic                  BUSY;
  modport slave (input SCLK, SDI, SEN, output SDO, REGS, WR_STROBE, WR_ADDR, FRAME_ERROR, BUSY);
  modport master (output SCLK, SDI, SEN, input SDO, REGS, WR_STROBE, WR_ADDR, FRAME_ERROR, BUSY);
endinterface

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: oversampled SPI slave with 16-bit R/W frames into an 8-bit register file
// define SPI_SLAVE_READBACK_EN to drive read data on SDO; otherwise SDO is tied low
module spi_slave_regfile #(
  parameter int N_REGS      = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic BUS_CLK,
  input logic BUS_RST,
  spi_slave_regfile_if.slave bus
);
  localparam int AW = N_REGS > 1 ? $clog2(N_REGS) : 1;
  localparam logic [7:0] NR = 8'(N_REGS);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_sy, sdi_sy, sen_sy;
  logic sclk_q, sen_q, sclk_s, sdi_s, sen_s;
  logic sen_rise, sen_fall, rise, fall;
  logic [4:0] cnt;
  logic [15:0] sr;
  logic [7:0] regs [N_REGS];
  logic commit, pend, wr_strobe, frame_error, sdo, busy;
  logic shifting, last, bad_end, extra, clr, st;
  logic [6:0] wr_addr;
  // SEN sync resets high so a frame interrupted by reset is ignored until SEN drops
  always_ff @(posedge BUS_CLK or posedge BUS_RST)
    if (BUS_RST) begin
      sclk_sy <= '0;
      sdi_sy  <= '0;
      sen_sy  <= '1;
      sclk_q  <= 1'b0;
      sen_q   <= 1'b1;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], bus.SCLK};
      sdi_sy  <= {sdi_sy[SYNC_STAGES-2:0], bus.SDI};
      sen_sy  <= {sen_sy[SYNC_STAGES-2:0], bus.SEN};
      sclk_q  <= sclk_s;
      sen_q   <= sen_s;
    end
  assign sclk_s   = sclk_sy[SYNC_STAGES-1];
  assign sdi_s    = sdi_sy[SYNC_STAGES-1];
  assign sen_s    = sen_sy[SYNC_STAGES-1];
  assign sen_rise = sen_s & ~sen_q;
  assign sen_fall = ~sen_s & sen_q;
  assign rise     = sen_s & sclk_s & ~sclk_q;
  assign fall     = sen_s & ~sclk_s & sclk_q;
  always_ff @(posedge BUS_CLK or posedge BUS_RST)
    if (BUS_RST) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (sen_fall) state_nx = IDLE;
    else if (state == IDLE && sen_rise) state_nx = CMD;
    else if (state == CMD && rise && cnt == 5'd7) state_nx = DATA;
    else if (state == DATA && rise && cnt == 5'd15) state_nx = DONE;
  end
  always_comb begin
    busy     = state != IDLE;
    shifting = rise && (state == CMD || state == DATA);
    last     = state == DATA && rise && cnt == 5'd15;
    bad_end  = sen_fall && state != IDLE && cnt != 5'd16;
    extra    = rise && state == DONE;
    clr      = commit && !sr[15] && sr[14:8] == 7'h7f && sr[0];
    st       = commit && !sr[15] && !clr && {1'b0, sr[14:8]} < NR;
  end
  always_ff @(posedge BUS_CLK or posedge BUS_RST)
    if (BUS_RST) begin
      cnt         <= '0;
      sr          <= '0;
      commit      <= 1'b0;
      pend        <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      frame_error <= 1'b0;
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else begin
      cnt         <= state == IDLE ? 5'd0 : shifting ? cnt + 5'd1 : cnt;
      sr          <= shifting ? {sr[14:0], sdi_s} : sr;
      commit      <= last;
      pend        <= st;
      wr_strobe   <= pend;
      wr_addr     <= pend ? sr[14:8] : wr_addr;
      frame_error <= (bad_end || extra) ? 1'b1 : clr ? 1'b0 : frame_error;
      if (st) regs[sr[8+AW-1:8]] <= sr[7:0];
    end
`ifdef SPI_SLAVE_READBACK_EN
  logic [7:0] so, rd;
  assign rd = ({1'b0, sr[6:0]} < NR) ? regs[sr[AW-1:0]] : 8'h00;
  // first data-phase falling edge presents MSB; the next seven shift the rest out
  always_ff @(posedge BUS_CLK or posedge BUS_RST)
    if (BUS_RST) {sdo, so} <= '0;
    else if (fall && state == DATA && cnt == 5'd8 && sr[7]) {sdo, so} <= {rd, 1'b0};
    else if (fall && state == DATA) {sdo, so} <= {so, 1'b0};
    else if (state == IDLE || (fall && state == DONE)) {sdo, so} <= '0;
`else
  assign sdo = 1'b0;
`endif
  for (genvar k = 0; k < N_REGS; k++) assign bus.REGS[8*k +: 8] = regs[k];
  assign bus.SDO         = sdo;
  assign bus.WR_STROBE   = wr_strobe;
  assign bus.WR_ADDR     = wr_addr;
  assign bus.FRAME_ERROR = frame_error;
  assign bus.BUSY        = busy;
endmodule

// File: doc/spi_slave_regfile.md
SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 SHALL have parameter N_REGS, default 16, meaning the number of 8-bit registers (1..128).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on SCLK/SDI/SEN (>=2).
REQ-003 SHALL have port BUS_CLK, input, 1, the single clock; all logic is synchronous to it.
REQ-004 SHALL have port BUS_RST, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port SCLK, input, 1, SPI serial clock, asynchronous to BUS_CLK.
REQ-006 SHALL have port SDI, input, 1, serial data from the master.
REQ-007 SHALL have port SEN, input, 1, frame enable; active-high, high for the whole frame.
REQ-008 SHALL have port SDO, output, 1, serial read data to the master.
REQ-009 SHALL have port REGS, output, 8*N_REGS, flat register image; register k occupies bits [8k+7:8k].
REQ-010 SHALL have port WR_STROBE, output, 1, one-cycle pulse after each committed write.
REQ-011 SHALL have port WR_ADDR, output, 7, address of the last committed write.
REQ-012 SHALL have port FRAME_ERROR, output, 1, sticky flag for a malformed frame.
REQ-013 SHALL have port BUSY, output, 1, high while a frame is in progress.

Function
REQ-014 SHALL resynchronize SCLK, SDI and SEN through SYNC_STAGES flops, then edge-detect SCLK; SCLK frequency SHALL be <= BUS_CLK/8.
REQ-015 SHALL use a 16-bit frame, MSB first: bit15 R/W (1 = read), bits14:8 address A, bits7:0 data.
REQ-016 SHALL sample SDI on each synchronized SCLK rising edge and update SDO on each synchronized SCLK falling edge.
REQ-017 SHALL implement FSM IDLE -> CMD on SEN rise; CMD -> DATA after 8 bits; DATA -> DONE after 16 bits; DONE -> IDLE on SEN fall.
REQ-018 SHALL, from any state, go to IDLE on SEN fall; if the bit count != 16, it SHALL set FRAME_ERROR and discard the frame without a write.
REQ-019 SHALL, in DONE, ignore further SCLK edges; extra edges SHALL set FRAME_ERROR, but the completed write remains committed.
REQ-020 SHALL, on a write frame with A < N_REGS, update register A on the cycle after bit 16 is sampled, then pulse WR_STROBE and load WR_ADDR on the next cycle.
REQ-021 SHALL, for a write with A >= N_REGS, discard the data with no WR_STROBE and no error.
REQ-022 SHALL, for a read frame, load register A (0x00 if A >= N_REGS) into the shift-out register at the falling edge after bit 8, and shift it MSB first on the next 8 falling edges.
REQ-023 SHALL hold SDO at 0 outside the read data phase.
REQ-024 SHALL assert BUSY from the cycle after synchronized SEN rises until the cycle after it falls.
REQ-025 SHALL ignore SCLK edges while SEN is low.
REQ-026 SHALL keep FRAME_ERROR set until reset, or until a write to address 0x7F with data bit0 = 1 clears it; that write SHALL NOT store data and SHALL NOT pulse WR_STROBE.

Reset
REQ-027 SHALL, on BUS_RST high, immediately clear all registers to 0x00, SDO, WR_STROBE, FRAME_ERROR and BUSY to 0, WR_ADDR to 0, and the FSM to IDLE.
REQ-028 SHALL, on reset mid-frame, abort the frame; after release it SHALL wait for SEN low before accepting a new frame.

Configuration
REQ-029 SHALL support macro SPI_SLAVE_READBACK_EN: when defined, read frames behave per REQ-022.
REQ-030 SHALL, when SPI_SLAVE_READBACK_EN is undefined, tie SDO to 0 and complete read frames without effect or error.

Verification
REQ-031 Write frame 0x0342 -> REGS[31:24] = 0x42, one WR_STROBE, WR_ADDR = 3.
REQ-032 Preload reg5 = 0xA7, send read frame 0x8500 -> SDO bits during the data phase are 1,0,1,0,0,1,1,1; registers unchanged.
REQ-033 SEN drops after 11 bits of 0x0255 -> reg2 unchanged, FRAME_ERROR = 1, no strobe; then write 0x7F01 -> FRAME_ERROR = 0.
REQ-034 Write 0x1455 with N_REGS = 16 -> no register changes, no strobe, FRAME_ERROR = 0; read 0x9400 -> SDO stays 0.
REQ-035 Assert BUS_RST after bit 12 of 0x0699, release it, then send 0x0611 -> reg6 = 0x11, reg6 never 0x99, exactly one strobe.
REQ-036 Build without SPI_SLAVE_READBACK_EN, read 0x8500 with reg5 = 0xA7 -> SDO constant 0, FRAME_ERROR = 0.
